// File: rtl/rpn_stack_engine.sv
// rpn_stack_engine
//   RPN stack calculator core. Takes one command per cmd_valid/cmd_ready handshake
//   and runs it against the stack. The top entry lives in register t_q. The entries
//   below it live in an inferred RAM with a 1-cycle synchronous read. Each command
//   returns exactly one rsp_valid pulse.
//   DIV and MOD use a restoring divider that takes DATA_W cycles.
//
// Ports
//   clk, reset    clock; synchronous active-high reset
//   cmd_valid     command offered (input)
//   cmd_ready     engine idle; a command is accepted when valid and ready are both high
//   cmd_op        4-bit opcode (input)
//   cmd_data      operand for PUSH / SHIFT_PUSH (input)
//   rsp_valid     one-cycle completion pulse
//   rsp_error     command was rejected; held until the next rsp_valid
//   rsp_top       top of stack after the command (0 if the stack is empty)
//   stack_size    current entry count
//   empty, full   stack_size == 0 / stack_size == DEPTH
module rpn_stack_engine #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int IN_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_op,
    input  logic [IN_W-1:0]            cmd_data,
    output logic                       rsp_valid,
    output logic                       rsp_error,
    output logic [DATA_W-1:0]          rsp_top,
    output logic [$clog2(DEPTH+1)-1:0] stack_size,
    output logic                       empty,
    output logic                       full
);
    localparam int SW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [3:0] OP_ADD   = 4'd0,  OP_SUB  = 4'd1, OP_MUL  = 4'd2,
                           OP_DIV   = 4'd3,  OP_MOD  = 4'd4, OP_POP  = 4'd5,
                           OP_DUP   = 4'd6,  OP_SWAP = 4'd7, OP_PUSH = 4'd8,
                           OP_SHIFT = 4'd9,  OP_CLR  = 4'd10;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_DIVIDE, S_COMMIT} state_t;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [IN_W-1:0]     data_q, data_d;
    logic [DATA_W-1:0]   t_q, t_d;
    logic [SW-1:0]       size_q, size_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_error_q, rsp_error_d;
    logic [DATA_W-1:0]   rsp_top_q, rsp_top_d;

    // The RAM holds the entries below the top: mem[0..DEPTH-2].
    logic [DATA_W-1:0]   mem [DEPTH-1];
    logic [DATA_W-1:0]   mem_rd_q;     // S, i.e. mem[size-2]
    logic [AW-1:0]       rd_addr;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W:0]     rem_sh;
    logic                is_div;

    // The read address depends only on size_q, which is frozen for the whole
    // command. So mem_rd_q holds S from EXEC through COMMIT.
    assign rd_addr = (size_q >= SW'(2)) ? AW'(size_q - SW'(2)) : '0;

    always_ff @(posedge clk) begin
        mem_rd_q <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign cmd_ready  = (state_q == S_IDLE) && !reset;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_error  = rsp_error_q;
    assign rsp_top    = rsp_top_q;
    assign stack_size = size_q;
    assign empty      = (size_q == '0);
    assign full       = (size_q == SW'(DEPTH));
    assign is_div     = (op_q == OP_DIV) || (op_q == OP_MOD);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        t_d         = t_q;
        size_d      = size_q;
        err_d       = err_q;
        res_d       = res_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_error_d = rsp_error_q;
        rsp_top_d   = rsp_top_q;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = t_q;
        rem_sh      = '0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                case (op_q)
                    OP_ADD, OP_SUB, OP_MUL, OP_SWAP: err_d = (size_q < SW'(2));
                    OP_DIV, OP_MOD:   err_d = (size_q < SW'(2)) || (mem_rd_q == '0);
                    OP_POP, OP_SHIFT: err_d = (size_q == '0);
                    OP_DUP:           err_d = (size_q == '0) || (size_q == SW'(DEPTH));
                    OP_PUSH:          err_d = (size_q == SW'(DEPTH));
                    OP_CLR:           err_d = 1'b0;
                    default:          err_d = 1'b1;
                endcase
                case (op_q)
                    OP_ADD:   res_d = t_q + mem_rd_q;
                    OP_SUB:   res_d = t_q - mem_rd_q;
                    OP_MUL:   res_d = t_q * mem_rd_q;
                    OP_PUSH:  res_d = DATA_W'(data_q);
                    OP_SHIFT: res_d = (t_q << IN_W) | DATA_W'(data_q);
                    default:  res_d = t_q;
                endcase
                // Seed the divider: the dividend shifts out of quo_q into rem_q.
                quo_d   = t_q;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = (is_div && !err_d) ? S_DIVIDE : S_COMMIT;
            end
            S_DIVIDE: begin
                rem_sh = {rem_q, quo_q[DATA_W-1]};
                if (rem_sh >= {1'b0, mem_rd_q}) begin
                    rem_d = DATA_W'(rem_sh - {1'b0, mem_rd_q});
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_W-1)) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_error_d = err_q;
                if (!err_q) begin
                    case (op_q)
                        OP_ADD, OP_SUB, OP_MUL: begin
                            t_d    = res_q;
                            size_d = size_q - SW'(1);
                        end
                        OP_DIV: begin
                            t_d    = quo_q;
                            size_d = size_q - SW'(1);
                        end
                        OP_MOD: begin
                            t_d    = rem_q;
                            size_d = size_q - SW'(1);
                        end
                        OP_POP: begin
                            t_d    = (size_q >= SW'(2)) ? mem_rd_q : '0;
                            size_d = size_q - SW'(1);
                        end
                        OP_DUP: begin
                            wr_en   = 1'b1;
                            wr_addr = AW'(size_q - SW'(1));
                            size_d  = size_q + SW'(1);
                        end
                        OP_SWAP: begin
                            wr_en   = 1'b1;
                            wr_addr = rd_addr;
                            t_d     = mem_rd_q;
                        end
                        OP_PUSH: begin
                            // Old top moves down into the RAM only if there was one.
                            wr_en   = (size_q != '0);
                            wr_addr = AW'(size_q - SW'(1));
                            t_d     = res_q;
                            size_d  = size_q + SW'(1);
                        end
                        OP_SHIFT: t_d = res_q;
                        OP_CLR: begin
                            t_d    = '0;
                            size_d = '0;
                        end
                        default: ;
                    endcase
                end
                rsp_top_d = (size_d == '0) ? '0 : t_d;
            end
            default: state_d = S_IDLE;
        endcase

        // A reset that lands in COMMIT must not corrupt the RAM.
        if (reset) wr_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            data_q      <= '0;
            t_q         <= '0;
            size_q      <= '0;
            err_q       <= 1'b0;
            res_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_top_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            t_q         <= t_d;
            size_q      <= size_d;
            err_q       <= err_d;
            res_q       <= res_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_top_q   <= rsp_top_d;
        end
    end
endmodule

// File: tb/tb_rpn_stack_engine.sv
// Testbench for rpn_stack_engine. The stimulus is directed commands. Each command
// queues its expected response, and a negedge monitor checks every rsp_valid pulse
// against that queue, including the response latency.
module tb_rpn_stack_engine;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int IN_W   = 8;
    localparam int SW     = $clog2(DEPTH+1);

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, DIV = 4'd3, MOD = 4'd4,
                           POP = 4'd5, DUP = 4'd6, SWAP = 4'd7, PUSH = 4'd8,
                           SHP = 4'd9, CLR = 4'd10;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [IN_W-1:0]   cmd_data;
    logic              rsp_valid;
    logic              rsp_error;
    logic [DATA_W-1:0] rsp_top;
    logic [SW-1:0]     stack_size;
    logic              empty;
    logic              full;

    rpn_stack_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IN_W(IN_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_error(rsp_error), .rsp_top(rsp_top), .stack_size(stack_size),
        .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                id;
        logic              err;
        logic [DATA_W-1:0] top;
        int                size;
        int                lat;
        int                acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   vid   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every response pulse is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp_valid", 64'(rsp_valid), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk($sformatf("v%0d.err", e.id),   64'(rsp_error),  64'(e.err));
                chk($sformatf("v%0d.top", e.id),   64'(rsp_top),    64'(e.top));
                chk($sformatf("v%0d.size", e.id),  64'(stack_size), 64'(e.size));
                chk($sformatf("v%0d.empty", e.id), 64'(empty),      64'(e.size == 0));
                chk($sformatf("v%0d.full", e.id),  64'(full),       64'(e.size == DEPTH));
                chk($sformatf("v%0d.latency", e.id), 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [3:0] op, input logic [IN_W-1:0] d, input logic e_err,
                        input logic [DATA_W-1:0] e_top, input int e_size, input bit exp_rsp);
        int   w;
        exp_t e;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (cmd_ready !== 1'b1) begin
            chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        if (exp_rsp) begin
            e.id   = vid;
            e.err  = e_err;
            e.top  = e_top;
            e.size = e_size;
            e.acc  = cyc + 1;
            e.lat  = ((op == DIV || op == MOD) && !e_err) ? DATA_W + 3 : 3;
            q.push_back(e);
        end
        vid++;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst.size", 64'(stack_size), 64'd0);
        chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst.rsp_error", 64'(rsp_error), 64'd0);
        chk("rst.rsp_top", 64'(rsp_top), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.cmd_ready_after", 64'(cmd_ready), 64'd1);
        chk("rst.empty", 64'(empty), 64'd1);
        chk("rst.full", 64'(full), 64'd0);

        // SUB with wrap.
        send(PUSH, 8'd5, 0, 32'd5, 1, 1);
        send(PUSH, 8'd3, 0, 32'd3, 2, 1);
        send(SUB,  8'd0, 0, 32'hFFFF_FFFE, 1, 1);
        send(CLR,  8'd0, 0, 32'd0, 0, 1);
        // SHIFT_PUSH chain.
        send(PUSH, 8'h12, 0, 32'h12, 1, 1);
        send(SHP,  8'h34, 0, 32'h1234, 1, 1);
        send(SHP,  8'h56, 0, 32'h123456, 1, 1);
        send(CLR,  8'd0, 0, 32'd0, 0, 1);
        // DIV, divide-by-zero, illegal op, MUL, MOD, DUP.
        send(PUSH, 8'd7,   0, 32'd7, 1, 1);
        send(PUSH, 8'd100, 0, 32'd100, 2, 1);
        send(DIV,  8'd0,   0, 32'd14, 1, 1);
        send(PUSH, 8'd0,   0, 32'd0, 2, 1);
        send(SWAP, 8'd0,   0, 32'd14, 2, 1);
        send(MOD,  8'd0,   1, 32'd14, 2, 1);
        send(4'd15, 8'd0,  1, 32'd14, 2, 1);
        send(ADD,  8'd0,   0, 32'd14, 1, 1);
        send(PUSH, 8'd3,   0, 32'd3, 2, 1);
        send(MUL,  8'd0,   0, 32'd42, 1, 1);
        send(PUSH, 8'd100, 0, 32'd100, 2, 1);
        send(MOD,  8'd0,   0, 32'd16, 1, 1);
        send(DUP,  8'd0,   0, 32'd16, 2, 1);
        send(ADD,  8'd0,   0, 32'd32, 1, 1);
        send(POP,  8'd0,   0, 32'd0, 0, 1);
        // Underflow and illegal ops on an empty stack.
        send(ADD,   8'd0, 1, 32'd0, 0, 1);
        send(POP,   8'd0, 1, 32'd0, 0, 1);
        send(DUP,   8'd0, 1, 32'd0, 0, 1);
        send(4'd12, 8'd0, 1, 32'd0, 0, 1);
        send(SWAP,  8'd0, 1, 32'd0, 0, 1);
        send(SHP,   8'd1, 1, 32'd0, 0, 1);
        send(DIV,   8'd0, 1, 32'd0, 0, 1);
        send(CLR,   8'd0, 0, 32'd0, 0, 1);
        // ADD wrap-around.
        send(PUSH, 8'hFF, 0, 32'hFF, 1, 1);
        send(SHP,  8'hFF, 0, 32'hFFFF, 1, 1);
        send(SHP,  8'hFF, 0, 32'hFF_FFFF, 1, 1);
        send(SHP,  8'hFF, 0, 32'hFFFF_FFFF, 1, 1);
        send(PUSH, 8'd2,  0, 32'd2, 2, 1);
        send(ADD,  8'd0,  0, 32'd1, 1, 1);
        send(CLR,  8'd0,  0, 32'd0, 0, 1);
        // Fill to full, overflow, then pop back to empty.
        for (int i = 0; i < DEPTH; i++) send(PUSH, IN_W'(i), 0, DATA_W'(i), i + 1, 1);
        send(PUSH, 8'd99, 1, DATA_W'(DEPTH - 1), DEPTH, 1);
        send(DUP,  8'd0,  1, DATA_W'(DEPTH - 1), DEPTH, 1);
        for (int k = 1; k <= DEPTH; k++)
            send(POP, 8'd0, 0, (k < DEPTH) ? DATA_W'(DEPTH - 1 - k) : '0, DEPTH - k, 1);
        // Refill, then CLEAR from full.
        for (int i = 0; i < DEPTH; i++) send(PUSH, IN_W'(i + 1), 0, DATA_W'(i + 1), i + 1, 1);
        send(CLR, 8'd0, 0, 32'd0, 0, 1);
        drain();

        // Reset in the middle of a divide: no response, stack cleared.
        send(PUSH, 8'd9,  0, 32'd9, 1, 1);
        send(PUSH, 8'd50, 0, 32'd50, 2, 1);
        drain();
        send(DIV, 8'd0, 0, 32'd0, 0, 0);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("divrst.size", 64'(stack_size), 64'd0);
        chk("divrst.empty", 64'(empty), 64'd1);
        chk("divrst.cmd_ready", 64'(cmd_ready), 64'd0);
        chk("divrst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("divrst.rsp_top", 64'(rsp_top), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("divrst.cmd_ready_after", 64'(cmd_ready), 64'd1);
        repeat (DATA_W + 8) @(negedge clk);
        send(PUSH, 8'd1, 0, 32'd1, 1, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Overall watchdog so the run always ends.
    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
